data_mem_ctrl: RTL and testbench

//  Responder for the control unit's mem_read/mem_write strobes: runs a load/store

---
 rtl/data_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: turns mem_read/mem_write strobes into a req/ack
// bus cycle with byte-lane steering, load extension, misalignment check and timeout.
module data_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic              access, aligned;
  logic              stall_c, misalign_c, req_c;
  logic [3:0]        be_nx;
  logic [31:0]       wdata_nx;
  logic [31:0]       load_ext;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;

  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        be_r;
  logic [31:0]       wdata_r;
  logic [2:0]        f3_r;
  logic [1:0]        lane_r;
  logic [15:0]       cnt;
  logic              err_r;
  logic [31:0]       rdata_r;

  assign access = mem_read | mem_write;

  // Illegal funct3 encodings fall into the default and are reported as misaligned.
  always_comb begin
    aligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = ~addr[0];
      3'b010:         aligned = (addr[1:0] == 2'b00);
      default:        aligned = 1'b0;
    endcase
  end

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = '0;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          be_nx    = 4'b0001 << addr[1:0];
          wdata_nx = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_nx    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_nx = {2{wdata[15:0]}};
        end
        default: begin
          be_nx    = 4'b1111;
          wdata_nx = wdata;
        end
      endcase
    end
  end

  always_comb begin
    lane_byte = bus_rdata[7:0];
    case (lane_r)
      2'd0: lane_byte = bus_rdata[7:0];
      2'd1: lane_byte = bus_rdata[15:8];
      2'd2: lane_byte = bus_rdata[23:16];
      2'd3: lane_byte = bus_rdata[31:24];
      default: lane_byte = bus_rdata[7:0];
    endcase
    lane_half = lane_r[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_r)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'd0, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_ext = {16'd0, lane_half};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    req_c      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            stall_c  = 1'b1;
            state_nx = BUSY;
          end else begin
            misalign_c = 1'b1;
          end
        end
      end
      BUSY: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (bus_ack || cnt == TO_LAST) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request inputs are ignored while DONE because they still belong to the retiring access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      be_r    <= '0;
      wdata_r <= '0;
      f3_r    <= '0;
      lane_r  <= '0;
      cnt     <= '0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && aligned) begin
            we_r    <= mem_write;
            addr_r  <= {addr[ADDR_W-1:2], 2'b00};
            be_r    <= be_nx;
            wdata_r <= wdata_nx;
            f3_r    <= funct3;
            lane_r  <= addr[1:0];
            cnt     <= '0;
            err_r   <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + 16'd1;
          if (bus_ack) begin
            rdata_r <= load_ext;
          end else if (cnt == TO_LAST) begin
            rdata_r <= '0;
            err_r   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational strobes are masked by reset so nothing leaks out while rst_n is low.
  assign stall     = stall_c & rst_n;
  assign misalign  = misalign_c & rst_n;
  assign bus_req   = req_c;
  assign bus_we    = req_c & we_r;
  assign bus_addr  = req_c ? addr_r : '0;
  assign bus_be    = req_c ? be_r : '0;
  assign bus_wdata = req_c ? wdata_r : '0;
  assign bus_err   = (state == DONE) & err_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios followed by random
// accesses, each checked against a byte-level reference model.
module tb_data_mem_ctrl;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misalign, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, legality, lanes and extension.
  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00)      return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else                       return 4;
  endfunction

  function automatic bit model_aligned(input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return legal && ((a % acc_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] model_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned m;
    if (!we) return 4'b1111;
    m = ((1 << acc_size(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (acc_size(f3))
      1: return {4{wd[7:0]}};
      2: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int unsigned sz;
    logic [31:0] sh, mask, v;
    sz = acc_size(f3);
    sh = rd >> (8 * (a % 4));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = sh & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // One complete access; ack_delay >= TIMEOUT means memory never answers.
  task automatic apply_stimulus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input int ack_delay);
    bit ok, timeout;
    int exp_busy, stalls;
    ok       = model_aligned(f3, a);
    timeout  = (ack_delay >= TIMEOUT);
    exp_busy = timeout ? TIMEOUT : ack_delay + 1;

    @(negedge clk);
    mem_write = we;
    mem_read  = we ? 1'($urandom_range(0, 1)) : 1'b1;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    if (!ok) begin
      check_output("misalign_pulse", 32'(misalign), 32'd1);
      check_output("misalign_stall", 32'(stall), 32'd0);
      check_output("misalign_req", 32'(bus_req), 32'd0);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      check_output("misalign_one_cycle", 32'(misalign), 32'd0);
      check_output("misalign_no_req", 32'(bus_req), 32'd0);
      return;
    end
    check_output("idle_stall", 32'(stall), 32'd1);
    check_output("idle_no_misalign", 32'(misalign), 32'd0);
    check_output("idle_req_low", 32'(bus_req), 32'd0);
    stalls = 1;

    for (int i = 0; i < exp_busy; i++) begin
      @(negedge clk);
      bus_ack   = (i == ack_delay);
      bus_rdata = (i == ack_delay) ? rd : $urandom;
      #1;
      check_output("busy_req", 32'(bus_req), 32'd1);
      check_output("busy_we", 32'(bus_we), 32'(we));
      check_output("busy_addr", bus_addr, a & 32'hFFFF_FFFC);
      check_output("busy_be", 32'(bus_be), 32'(model_be(we, f3, a)));
      if (we) check_output("busy_wdata", bus_wdata, model_wdata(f3, wd));
      else    check_output("busy_wdata_ld", bus_wdata, 32'd0);
      if (stall) stalls++;
    end

    @(negedge clk);
    bus_ack   = timeout;
    bus_rdata = $urandom;
    #1;
    check_output("done_stall", 32'(stall), 32'd0);
    check_output("done_req", 32'(bus_req), 32'd0);
    check_output("done_be_zero", 32'(bus_be), 32'd0);
    check_output("done_we_zero", 32'(bus_we), 32'd0);
    check_output("done_bus_err", 32'(bus_err), 32'(timeout));
    check_output("stall_cycles", 32'(stalls), 32'(exp_busy + 1));
    if (timeout)  check_output("done_rdata_timeout", rdata, 32'd0);
    else if (!we) check_output("done_rdata", rdata, model_load(f3, a, rd));

    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_output("after_err_clear", 32'(bus_err), 32'd0);
    check_output("after_req", 32'(bus_req), 32'd0);
    check_output("after_stall", 32'(stall), 32'd0);
    bus_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    #12;
    check_output("reset_stall", 32'(stall), 32'd0);
    check_output("reset_req", 32'(bus_req), 32'd0);
    check_output("reset_rdata", rdata, 32'd0);
    check_output("reset_err", 32'(bus_err), 32'd0);
    check_output("reset_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed: LW with ack wait");
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
    $display("[TB] directed: LB / LBU lane 3");
    apply_stimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
    apply_stimulus(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
    apply_stimulus(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 1);
    apply_stimulus(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 1);
    $display("[TB] directed: SH upper half, SB lane 1");
    apply_stimulus(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0);
    apply_stimulus(1'b1, 3'b000, 32'h201, 32'h1234_ABCD, 32'h0, 3);
    $display("[TB] directed: misaligned / illegal");
    apply_stimulus(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    apply_stimulus(1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    $display("[TB] directed: SW timeout with late ack");
    apply_stimulus(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 100);
    apply_stimulus(1'b0, 3'b010, 32'h304, 32'h0, 32'h1111_2222, TIMEOUT - 1);

    $display("[TB] directed: reset mid-access");
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("rst_busy_req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("rst_req_drop", 32'(bus_req), 32'd0);
    check_output("rst_stall_drop", 32'(stall), 32'd0);
    check_output("rst_be_zero", 32'(bus_be), 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rst_release_req", 32'(bus_req), 32'd0);
    check_output("rst_release_stall", 32'(stall), 32'd0);
    apply_stimulus(1'b0, 3'b010, 32'h400, 32'h0, 32'h5A5A_A5A5, 1);

    $display("[TB] random accesses");
    for (int n = 0; n < 30; n++) begin
      logic [2:0]  rf3;
      logic [31:0] ra;
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom & 32'h0000_FFFF;
      apply_stimulus(1'($urandom_range(0, 1)), rf3, ra, $urandom, $urandom,
                     int'($urandom_range(0, TIMEOUT + 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
